// File: rtl/debug_step_controller_if.sv
// debug_step_controller_if: switch, peek and step signals between the board side and the step controller
interface debug_step_controller_if;
    logic        switchRun;
    logic [4:0]  SwitchSelector;
    logic [31:0] rf_rdata;
    logic [4:0]  dbg_rf_addr;
    logic [31:0] reg_read_data_1;
    logic        cpu_step_en;
    logic [31:0] step_count;
    logic        busy;
    modport master (
        output switchRun, SwitchSelector, rf_rdata,
        input  dbg_rf_addr, reg_read_data_1, cpu_step_en, step_count, busy
    );
    modport slave (
        input  switchRun, SwitchSelector, rf_rdata,
        output dbg_rf_addr, reg_read_data_1, cpu_step_en, step_count, busy
    );
endinterface

// File: rtl/debug_step_controller.sv
// debug_step_controller: debounced single-step pulse generator and register-file peek port for the MIPS core
module debug_step_controller #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int RUN_STEPS       = 1
) (
    input logic                    clkFast,
    input logic                    reset_n,
    debug_step_controller_if.slave dbg
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] STEP         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;
    localparam logic [7:0] DB_LAST      = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] RS_LAST      = 8'(RUN_STEPS - 1);
    logic        sync_1;
    logic        run_s;
    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [31:0] step_cnt;
    logic [4:0]  rf_addr;
    logic [31:0] peek;
    assign dbg.cpu_step_en     = state == STEP;
    assign dbg.busy            = state != IDLE;
    assign dbg.step_count      = step_cnt;
    assign dbg.dbg_rf_addr     = rf_addr;
    assign dbg.reg_read_data_1 = peek;
    // two-flop synchronizer; run_s is the only view of the switch
    always_ff @(posedge clkFast or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            run_s  <= 1'b0;
        end else begin
            sync_1 <= dbg.switchRun;
            run_s  <= sync_1;
        end
    end
    // next state: press debounce, step burst, release debounce sharing one counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (run_s) begin
                    state_nx = DEBOUNCE;
                    cnt_nx   = 8'd1;
                end
            end
            DEBOUNCE: begin
                if (!run_s) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end else if (cnt == DB_LAST) begin
                    state_nx = STEP;
                    cnt_nx   = 8'd0;
                end else
                    cnt_nx = cnt + 8'd1;
            end
            STEP: begin
                if (cnt == RS_LAST) begin
                    state_nx = WAIT_RELEASE;
                    cnt_nx   = 8'd0;
                end else
                    cnt_nx = cnt + 8'd1;
            end
            default: begin
                if (run_s)
                    cnt_nx = 8'd0;
                else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end else
                    cnt_nx = cnt + 8'd1;
            end
        endcase
    end
    // FSM state and shared counter registers
    always_ff @(posedge clkFast or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // count every issued step, wrapping naturally at 2^32
    always_ff @(posedge clkFast or negedge reset_n) begin
        if (!reset_n)
            step_cnt <= 32'd0;
        else if (state == STEP)
            step_cnt <= step_cnt + 32'd1;
    end
    // peek port: register the index, then register the read data with $zero forced to 0
    always_ff @(posedge clkFast or negedge reset_n) begin
        if (!reset_n) begin
            rf_addr <= 5'd0;
            peek    <= 32'd0;
        end else begin
            rf_addr <= dbg.SwitchSelector;
            peek    <= rf_addr == 5'd0 ? 32'd0 : dbg.rf_rdata;
        end
    end
endmodule

// File: tb/tb_debug_step_controller.sv
// tb_debug_step_controller: directed and random checks of three controller configurations against a run-length reference model
module tb_debug_step_controller;
    logic        clkFast = 1'b0;
    logic        reset_n = 1'b0;
    logic        sw      = 1'b0;
    logic [4:0]  sel     = 5'd0;
    int          errors  = 0;
    int          checks  = 0;
    always #5 clkFast = ~clkFast;

    debug_step_controller_if bus_a ();
    debug_step_controller_if bus_b ();
    debug_step_controller_if bus_c ();
    assign bus_a.switchRun = sw;
    assign bus_b.switchRun = sw;
    assign bus_c.switchRun = sw;
    assign bus_a.SwitchSelector = sel;
    assign bus_b.SwitchSelector = sel;
    assign bus_c.SwitchSelector = sel;
    assign bus_a.rf_rdata = 32'h1000_0000 + {27'd0, bus_a.dbg_rf_addr};
    assign bus_b.rf_rdata = 32'h1000_0000 + {27'd0, bus_b.dbg_rf_addr};
    assign bus_c.rf_rdata = 32'h1000_0000 + {27'd0, bus_c.dbg_rf_addr};

    debug_step_controller dut_a (.clkFast(clkFast), .reset_n(reset_n), .dbg(bus_a));
    debug_step_controller #(.RUN_STEPS(3)) dut_b (.clkFast(clkFast), .reset_n(reset_n), .dbg(bus_b));
    debug_step_controller #(.DEBOUNCE_CYCLES(2), .RUN_STEPS(4)) dut_c (.clkFast(clkFast), .reset_n(reset_n), .dbg(bus_c));

    logic [2:0]  en_o;
    logic [2:0]  busy_o;
    logic [31:0] cnt_o  [3];
    logic [31:0] data_o [3];
    logic [4:0]  addr_o [3];
    assign en_o   = {bus_c.cpu_step_en, bus_b.cpu_step_en, bus_a.cpu_step_en};
    assign busy_o = {bus_c.busy, bus_b.busy, bus_a.busy};
    assign cnt_o[0] = bus_a.step_count;
    assign cnt_o[1] = bus_b.step_count;
    assign cnt_o[2] = bus_c.step_count;
    assign data_o[0] = bus_a.reg_read_data_1;
    assign data_o[1] = bus_b.reg_read_data_1;
    assign data_o[2] = bus_c.reg_read_data_1;
    assign addr_o[0] = bus_a.dbg_rf_addr;
    assign addr_o[1] = bus_b.dbg_rf_addr;
    assign addr_o[2] = bus_c.dbg_rf_addr;

    // reference model: run lengths of the synchronized switch decide press, burst and release
    int          md  [3] = '{8, 8, 2};
    int          mrs [3] = '{1, 3, 4};
    bit          armed  [3];
    int          streak [3];
    int          left   [3];
    logic [31:0] mcnt   [3];
    logic        ms1, ms2;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    int          first, last, n_en, k;
    logic [4:0]  sweep [19];

    task automatic model_reset();
        ms1 = 1'b0;
        ms2 = 1'b0;
        maddr = 5'd0;
        mdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            armed[i] = 1'b1;
            streak[i] = 0;
            left[i] = 0;
            mcnt[i] = 32'd0;
        end
    endtask

    task automatic model_edge();
        logic r;
        r = ms2;
        for (int i = 0; i < 3; i++) begin
            if (left[i] > 0) begin
                mcnt[i] = mcnt[i] + 32'd1;
                left[i]--;
                if (left[i] == 0) begin
                    armed[i] = 1'b0;
                    streak[i] = 0;
                end
            end else if (armed[i]) begin
                streak[i] = r ? streak[i] + 1 : 0;
                if (streak[i] == md[i]) begin
                    left[i] = mrs[i];
                    streak[i] = 0;
                end
            end else begin
                streak[i] = r ? 0 : streak[i] + 1;
                if (streak[i] == md[i]) begin
                    armed[i] = 1'b1;
                    streak[i] = 0;
                end
            end
        end
        ms2 = ms1;
        ms1 = sw;
        mdata = maddr == 5'd0 ? 32'd0 : 32'h1000_0000 + {27'd0, maddr};
        maddr = sel;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string ph);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_en%0d", ph, i), 32'(en_o[i]), 32'(left[i] > 0));
            chk($sformatf("%s_busy%0d", ph, i), 32'(busy_o[i]), 32'(!(armed[i] && streak[i] == 0 && left[i] == 0)));
            chk($sformatf("%s_cnt%0d", ph, i), cnt_o[i], mcnt[i]);
            chk($sformatf("%s_addr%0d", ph, i), 32'(addr_o[i]), 32'(maddr));
            chk($sformatf("%s_data%0d", ph, i), data_o[i], mdata);
        end
    endtask

    task automatic tick();
        @(posedge clkFast);
        if (reset_n) model_edge();
        @(negedge clkFast);
        chk_all("cyc");
    endtask

    task automatic press(input int hi, input int lo);
        sw = 1'b1;
        repeat (hi) tick();
        sw = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        model_reset();
        #7;
        chk_all("rst");
        @(negedge clkFast);
        reset_n = 1'b1;
        tick();
        // single step: latency and pulse count
        first = -1;
        n_en = 0;
        sw = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            if (j == 17) sw = 1'b0;
            tick();
            if (en_o[0]) begin
                n_en++;
                if (first < 0) first = j;
            end
        end
        chk("single_latency", first, 10);
        chk("single_pulses", n_en, 1);
        chk("single_cnt", cnt_o[0], 1);
        chk("single_idle", 32'(busy_o[0]), 0);
        repeat (4) press(16, 24);
        chk("five_presses", cnt_o[0], 5);
        // bounce rejection followed by a real hold
        n_en = 0;
        for (int p = 1; p <= 7; p++) begin
            sw = 1'b1;
            for (int j = 0; j < p; j++) begin
                tick();
                n_en += int'(en_o[0]) + int'(en_o[1]);
            end
            sw = 1'b0;
            repeat (2) begin
                tick();
                n_en += int'(en_o[0]) + int'(en_o[1]);
            end
        end
        chk("bounce_no_step", n_en, 0);
        press(20, 30);
        chk("bounce_then_hold", cnt_o[0], 6);
        // burst of three on a long hold
        n_en = 0;
        first = -1;
        last = -1;
        sw = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            tick();
            if (en_o[1]) begin
                n_en++;
                if (first < 0) first = j;
                last = j;
            end
        end
        chk("burst_pulses", n_en, 3);
        chk("burst_contiguous", last - first, 2);
        chk("burst_hold_busy", 32'(busy_o[1]), 1);
        sw = 1'b0;
        repeat (30) tick();
        chk("burst_cnt", cnt_o[1], 21);
        chk("burst_released", 32'(busy_o[1]), 0);
        // peek sweep over 0 and 8..25
        sweep[0] = 5'd0;
        for (int j = 1; j < 19; j++) sweep[j] = 5'(j + 7);
        for (int j = 0; j < 19; j++) begin
            sel = sweep[j];
            tick();
            tick();
            chk($sformatf("peek_%0d", sweep[j]), data_o[0], sweep[j] == 5'd0 ? 32'd0 : 32'h1000_0000 + {27'd0, sweep[j]});
        end
        // random switch and selector activity
        for (int j = 0; j < 40; j++) begin
            sw = 1'($urandom_range(0, 1));
            sel = 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 20)) tick();
        end
        // reset pulse in the middle of a four-step burst
        sw = 1'b0;
        repeat (30) tick();
        sw = 1'b1;
        k = 0;
        while (!en_o[2] && k < 20) begin
            tick();
            k++;
        end
        chk("c_reaches_step", 32'(en_o[2]), 1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_en", 32'(en_o[2]), 0);
        chk("rst_mid_cnt", cnt_o[2], 0);
        model_reset();
        chk_all("rst_mid");
        sw = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("rst_mid_no_more", cnt_o[2], 0);
        // step counter wrap
        force dut_a.step_cnt = 32'hFFFF_FFFE;
        #1;
        release dut_a.step_cnt;
        mcnt[0] = 32'hFFFF_FFFE;
        press(16, 24);
        chk("wrap_ffffffff", cnt_o[0], 32'hFFFF_FFFF);
        press(16, 24);
        chk("wrap_zero", cnt_o[0], 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
